ddr_tx: RTL and testbench
=========================

// Module: ddr_tx
// PURPOSE
//  HDR-DDR transmit serializer for the I3C controller, counterpart of the DDR receive path.
//  - Driven by the DDR CCC FSM through a mode/enable handshake.
//  - Shifts preamble, data bytes, parity, CRC token and CRC value onto SDA, one bit per SCL edge
//    (both edges), MSB first.
//  - Feeds data bytes to the CRC engine; output goes to the SDA handler.
// PARAMETERS
//  CRC_TOKEN  4'hC  token sent in CRC_TOKEN mode
//  CRC_W      5     CRC value width
// PORTS
//  i_sys_clk                 in   1     system clock
//  i_sys_rst                 in   1     reset, asynchronous, active-low
//  i_sclgen_scl_pos_edge     in   1     1-cycle strobe, SCL rising edge
//  i_sclgen_scl_neg_edge     in   1     1-cycle strobe, SCL falling edge
//  i_ddrccc_tx_en            in   1     enable; low aborts the current mode
//  i_ddrccc_tx_mode          in   4     mode select, sampled only in IDLE
//  i_ddrccc_pre_bits         in   2     preamble bits, [1] sent first
//  i_regf_tx_data            in   8     byte for SERIAL_BYTE
//  i_crc_value               in   CRC_W computed CRC
//  i_crc_valid               in   1     i_crc_value is final
//  o_sdahnd_tx_sda           out  1     serial SDA drive value
//  o_ddrccc_tx_mode_done     out  1     1-cycle pulse, mode finished
//  o_ddrccc_tx_busy          out  1     high while in SHIFT or WAIT_CRC
//  o_crc_en                  out  1     CRC engine enable
//  o_crc_data_valid          out  1     1-cycle pulse, o_crc_data valid
//  o_crc_data                out  8     byte to CRC engine
// BEHAVIOUR
//  Reset values: all outputs 0, except o_sdahnd_tx_sda = 1 (bus idle high).
//    Also clears FSM to IDLE, bit counter, byte_num and par_word.
//  Modes and lengths:
//    PREAMBLE   4'b0000  2 bits  i_ddrccc_pre_bits
//    SERIAL_BYTE 4'b0011 8 bits  i_regf_tx_data
//    CRC_TOKEN  4'b0101  4 bits  CRC_TOKEN
//    PARITY     4'b0110  2 bits  P
//    CRC_VALUE  4'b0111  5 bits  i_crc_value
//    SDA_HIGH   4'b1000  1 bit   1
//    SDA_LOW    4'b1001  1 bit   0
//    Any other mode: stay IDLE, no done, SDA unchanged.
//  Parity bits:
//    P[1] = ^par_word[15,13,..,1]
//    P[0] = ~^par_word[14,12,..,0]  (even-bit XOR inverted)
//  FSM: IDLE, SHIFT, WAIT_CRC.
//  - IDLE & en=1 & valid mode:
//      load shift register and count = length-1; go SHIFT.
//      First bit appears on o_sdahnd_tx_sda the next cycle (latency 1).
//  - IDLE & en=1 & CRC_VALUE & !i_crc_valid: go WAIT_CRC.
//  - WAIT_CRC: wait for i_crc_valid, then load as above; en=0 returns to IDLE.
//  - SHIFT on (pos_edge | neg_edge) strobe:
//      count!=0: drive next bit, count--.
//      count==0: last bit has been held one edge; pulse mode_done next cycle; go IDLE.
//    SDA holds the last bit until the next load.
//  - An edge strobe in the load cycle is ignored; the first bit always lasts a full SCL half-period.
//  - Mode changes while busy are ignored.
//  - en=0 in SHIFT or WAIT_CRC: go IDLE next cycle, no done pulse, SDA holds its value.
//    byte_num and par_word are untouched.
//  Byte / parity tracking:
//  - At SERIAL_BYTE load: par_word[15:8] (byte_num=0) or par_word[7:0] (byte_num=1) <= data.
//  - byte_num toggles on SERIAL_BYTE completion.
//  - byte_num clears on PARITY completion or PREAMBLE load.
//  CRC interface:
//  - At SERIAL_BYTE load: o_crc_data <= byte, o_crc_data_valid pulses 1 cycle.
//  - o_crc_en sets at the first SERIAL_BYTE load.
//    Clears on CRC_VALUE completion, on an abort, or on a PREAMBLE load.
//  - o_crc_en is never cleared by PARITY or CRC_TOKEN.
//  Reset mid-shift: immediate return to reset values.
// TESTING
//  1. SERIAL_BYTE 8'hA5, edge every 4 clks
//     -> SDA 1,0,1,0,0,1,0,1; crc_data_valid 1 pulse with 8'hA5; done 1 clk after 8th edge.
//  2. Bytes 8'h3C, 8'hF0, then PARITY
//     -> par_word 16'h3CF0, SDA sends P = 2'b01 (P[1]=0, P[0]=1); byte_num returns to 0.
//  3. CRC_TOKEN, then CRC_VALUE with i_crc_value 5'h13 and i_crc_valid low 10 clks
//     -> SDA 1,1,0,0; then WAIT_CRC (busy=1); then 1,0,0,1,1; crc_en drops after done.
//  4. SERIAL_BYTE aborted by en=0 after 3 edges
//     -> IDLE, no done pulse, SDA holds; next SERIAL_BYTE restarts at MSB.
//  5. PREAMBLE 2'b10 with edge strobe in the load cycle
//     -> strobe ignored, SDA 1 then 0, done after the 2nd counted edge.
//  6. Reset asserted mid-CRC_VALUE
//     -> SDA=1, busy=0, crc_en=0 immediately; byte_num and par_word cleared.

Source files
------------

// File: rtl/ddr_tx.sv
// HDR-DDR transmit serializer: shifts preamble, data, parity, CRC token and CRC value onto
// SDA one bit per SCL edge (both edges), MSB first, and hands data bytes to the CRC engine.
module ddr_tx #(
    parameter logic [3:0] CRC_TOKEN = 4'hC,
    parameter int         CRC_W     = 5
) (
    input  logic             i_sys_clk,
    input  logic             i_sys_rst,
    input  logic             i_sclgen_scl_pos_edge,
    input  logic             i_sclgen_scl_neg_edge,
    input  logic             i_ddrccc_tx_en,
    input  logic [3:0]       i_ddrccc_tx_mode,
    input  logic [1:0]       i_ddrccc_pre_bits,
    input  logic [7:0]       i_regf_tx_data,
    input  logic [CRC_W-1:0] i_crc_value,
    input  logic             i_crc_valid,
    output logic             o_sdahnd_tx_sda,
    output logic             o_ddrccc_tx_mode_done,
    output logic             o_ddrccc_tx_busy,
    output logic             o_crc_en,
    output logic             o_crc_data_valid,
    output logic [7:0]       o_crc_data
);

    localparam logic [3:0] MODE_PREAMBLE  = 4'b0000;
    localparam logic [3:0] MODE_SERIAL    = 4'b0011;
    localparam logic [3:0] MODE_CRC_TOKEN = 4'b0101;
    localparam logic [3:0] MODE_PARITY    = 4'b0110;
    localparam logic [3:0] MODE_CRC_VALUE = 4'b0111;
    localparam logic [3:0] MODE_SDA_HIGH  = 4'b1000;
    localparam logic [3:0] MODE_SDA_LOW   = 4'b1001;

    localparam int         CRC_PAD  = 32'sd8 - CRC_W;
    localparam logic [2:0] CRC_LAST = 3'(CRC_W - 32'sd1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SHIFT    = 2'd1,
        ST_WAIT_CRC = 2'd2
    } state_t;

    function automatic logic mode_is_valid(input logic [3:0] mode);
        logic ok;
        case (mode)
            MODE_PREAMBLE, MODE_SERIAL, MODE_CRC_TOKEN, MODE_PARITY,
            MODE_CRC_VALUE, MODE_SDA_HIGH, MODE_SDA_LOW: ok = 1'b1;
            default:                                     ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Odd-indexed bits give P[1]; even-indexed bits give P[0], inverted.
    function automatic logic [1:0] ddr_parity(input logic [15:0] word);
        logic p_odd;
        logic p_even;
        p_odd  = 1'b0;
        p_even = 1'b0;
        for (int i = 32'sd0; i < 32'sd8; i++) begin
            p_odd  = p_odd ^ word[2*i+1];
            p_even = p_even ^ word[2*i];
        end
        return {p_odd, ~p_even};
    endfunction

    state_t      state_r;
    state_t      state_s;
    logic [3:0]  mode_r;
    logic [3:0]  load_mode_s;
    logic        load_s;
    logic        shift_s;
    logic        finish_s;
    logic        abort_s;
    logic        capture_s;
    logic        edge_s;
    logic [7:0]  load_word_s;
    logic [2:0]  load_cnt_s;
    logic [7:0]  crc_word_s;
    logic [1:0]  par_bits_s;

    logic [7:0]  shift_r;
    logic [2:0]  cnt_r;
    logic        sda_r;
    logic        done_r;
    logic        busy_r;
    logic        crc_en_r;
    logic        crc_dv_r;
    logic [7:0]  crc_data_r;
    logic        byte_num_r;
    logic [15:0] par_word_r;

    assign edge_s     = i_sclgen_scl_pos_edge | i_sclgen_scl_neg_edge;
    assign crc_word_s = 8'(i_crc_value) << CRC_PAD;
    assign par_bits_s = ddr_parity(par_word_r);

    // Next-state and control strobes
    always_comb begin
        state_s     = state_r;
        load_s      = 1'b0;
        shift_s     = 1'b0;
        finish_s    = 1'b0;
        abort_s     = 1'b0;
        capture_s   = 1'b0;
        load_mode_s = mode_r;
        case (state_r)
            ST_IDLE: begin
                load_mode_s = i_ddrccc_tx_mode;
                if (i_ddrccc_tx_en && mode_is_valid(i_ddrccc_tx_mode)) begin
                    capture_s = 1'b1;
                    if ((i_ddrccc_tx_mode == MODE_CRC_VALUE) && !i_crc_valid) begin
                        state_s = ST_WAIT_CRC;
                    end else begin
                        load_s  = 1'b1;
                        state_s = ST_SHIFT;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (!i_ddrccc_tx_en) begin
                    abort_s = 1'b1;
                    state_s = ST_IDLE;
                end else if (edge_s) begin
                    if (cnt_r != 3'd0) begin
                        shift_s = 1'b1;
                    end else begin
                        finish_s = 1'b1;
                        state_s  = ST_IDLE;
                    end
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            ST_WAIT_CRC: begin
                if (!i_ddrccc_tx_en) begin
                    abort_s = 1'b1;
                    state_s = ST_IDLE;
                end else if (i_crc_valid) begin
                    load_s  = 1'b1;
                    state_s = ST_SHIFT;
                end else begin
                    state_s = ST_WAIT_CRC;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Left-aligned bit pattern and last-bit index for the mode being loaded
    always_comb begin
        load_word_s = 8'h00;
        load_cnt_s  = 3'd0;
        case (load_mode_s)
            MODE_PREAMBLE: begin
                load_word_s = {i_ddrccc_pre_bits, 6'b000000};
                load_cnt_s  = 3'd1;
            end
            MODE_SERIAL: begin
                load_word_s = i_regf_tx_data;
                load_cnt_s  = 3'd7;
            end
            MODE_CRC_TOKEN: begin
                load_word_s = {CRC_TOKEN, 4'b0000};
                load_cnt_s  = 3'd3;
            end
            MODE_PARITY: begin
                load_word_s = {par_bits_s, 6'b000000};
                load_cnt_s  = 3'd1;
            end
            MODE_CRC_VALUE: begin
                load_word_s = crc_word_s;
                load_cnt_s  = CRC_LAST;
            end
            MODE_SDA_HIGH: begin
                load_word_s = 8'h80;
                load_cnt_s  = 3'd0;
            end
            MODE_SDA_LOW: begin
                load_word_s = 8'h00;
                load_cnt_s  = 3'd0;
            end
            default: begin
                load_word_s = 8'h00;
                load_cnt_s  = 3'd0;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
        if (!i_sys_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Shift register and SDA drive; SDA keeps its last bit outside SHIFT
    always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
        if (!i_sys_rst) begin
            sda_r   <= 1'b1;
            shift_r <= 8'h00;
            cnt_r   <= 3'd0;
            mode_r  <= MODE_PREAMBLE;
        end else begin
            if (load_s) begin
                sda_r   <= load_word_s[7];
                shift_r <= {load_word_s[6:0], 1'b0};
                cnt_r   <= load_cnt_s;
            end else if (shift_s) begin
                sda_r   <= shift_r[7];
                shift_r <= {shift_r[6:0], 1'b0};
                cnt_r   <= cnt_r - 3'd1;
            end
            if (capture_s) begin
                mode_r <= i_ddrccc_tx_mode;
            end
        end
    end

    // Handshake pulses towards the CCC FSM and the CRC engine
    always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
        if (!i_sys_rst) begin
            done_r     <= 1'b0;
            busy_r     <= 1'b0;
            crc_dv_r   <= 1'b0;
            crc_data_r <= 8'h00;
        end else begin
            done_r   <= finish_s;
            busy_r   <= (state_s != ST_IDLE);
            crc_dv_r <= load_s && (load_mode_s == MODE_SERIAL);
            if (load_s && (load_mode_s == MODE_SERIAL)) begin
                crc_data_r <= i_regf_tx_data;
            end
        end
    end

    // Byte pairing for the parity word and CRC engine enable
    always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
        if (!i_sys_rst) begin
            byte_num_r <= 1'b0;
            par_word_r <= 16'h0000;
            crc_en_r   <= 1'b0;
        end else begin
            if (load_s && (load_mode_s == MODE_SERIAL)) begin
                if (byte_num_r) begin
                    par_word_r[7:0] <= i_regf_tx_data;
                end else begin
                    par_word_r[15:8] <= i_regf_tx_data;
                end
            end
            if (finish_s && (mode_r == MODE_SERIAL)) begin
                byte_num_r <= ~byte_num_r;
            end else if ((finish_s && (mode_r == MODE_PARITY)) ||
                         (load_s && (load_mode_s == MODE_PREAMBLE))) begin
                byte_num_r <= 1'b0;
            end
            if (load_s && (load_mode_s == MODE_SERIAL)) begin
                crc_en_r <= 1'b1;
            end else if ((finish_s && (mode_r == MODE_CRC_VALUE)) || abort_s ||
                         (load_s && (load_mode_s == MODE_PREAMBLE))) begin
                crc_en_r <= 1'b0;
            end
        end
    end

    assign o_sdahnd_tx_sda       = sda_r;
    assign o_ddrccc_tx_mode_done = done_r;
    assign o_ddrccc_tx_busy      = busy_r;
    assign o_crc_en              = crc_en_r;
    assign o_crc_data_valid      = crc_dv_r;
    assign o_crc_data            = crc_data_r;

endmodule

// File: tb/tb_ddr_tx.sv
// Randomised scoreboard bench for ddr_tx: stimulus pushes expected SDA bits, done cycles and
// CRC bytes from a bit-level reference model; a negedge monitor pops and compares them.
module tb_ddr_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pos_edge = 1'b0;
    logic       neg_edge = 1'b0;
    logic       en = 1'b0;
    logic [3:0] mode = 4'd0;
    logic [1:0] pre = 2'd0;
    logic [7:0] data = 8'd0;
    logic [4:0] crc_value = 5'd0;
    logic       crc_valid = 1'b1;
    logic       sda;
    logic       done;
    logic       busy;
    logic       crc_en;
    logic       crc_dv;
    logic [7:0] crc_data;

    always #5 clk = ~clk;

    ddr_tx #(.CRC_TOKEN(4'hC), .CRC_W(5)) dut (
        .i_sys_clk             (clk),
        .i_sys_rst             (rst),
        .i_sclgen_scl_pos_edge (pos_edge),
        .i_sclgen_scl_neg_edge (neg_edge),
        .i_ddrccc_tx_en        (en),
        .i_ddrccc_tx_mode      (mode),
        .i_ddrccc_pre_bits     (pre),
        .i_regf_tx_data        (data),
        .i_crc_value           (crc_value),
        .i_crc_valid           (crc_valid),
        .o_sdahnd_tx_sda       (sda),
        .o_ddrccc_tx_mode_done (done),
        .o_ddrccc_tx_busy      (busy),
        .o_crc_en              (crc_en),
        .o_crc_data_valid      (crc_dv),
        .o_crc_data            (crc_data)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;

    bit         exp_sda_q[$];
    int         exp_done_q[$];
    logic [7:0] exp_crc_q[$];

    // Reference model state: the two bytes of the parity word, which one is next, crc_en, SDA
    logic [7:0] m_bytes[2];
    int         m_byte_num;
    bit         m_crc_en;
    bit         m_sda;

    logic [7:0] cur_val;
    int         cur_len;
    int         cur_idx;
    logic [3:0] cur_mode;
    bit         next_pos;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int ones(input logic [15:0] w, input int start);
        int n = 0;
        for (int i = start; i < 16; i += 2) n += (w[i] ? 1 : 0);
        return n;
    endfunction

    function automatic bit bit_at(input logic [7:0] v, input int i);
        return v[i[2:0]];
    endfunction

    // Value/length sent for a mode; bit k on the wire is val[len-1-k]
    task automatic model_pattern(input logic [3:0] m, output logic [7:0] val, output int len);
        logic [15:0] w;
        w = {m_bytes[0], m_bytes[1]};
        val = 8'h00;
        len = 0;
        case (m)
            4'd0: begin val = {6'd0, pre}; len = 2; end
            4'd3: begin val = data; len = 8; end
            4'd5: begin val = 8'h0C; len = 4; end
            4'd6: begin
                val[1] = ((ones(w, 1) % 2) == 1);
                val[0] = ((ones(w, 0) % 2) == 0);
                len = 2;
            end
            4'd7: begin val = {3'd0, crc_value}; len = 5; end
            4'd8: begin val = 8'h01; len = 1; end
            4'd9: begin val = 8'h00; len = 1; end
            default: len = 0;
        endcase
    endtask

    // Scoreboard monitor, sampling on the inactive clock edge
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if ((pos_edge || neg_edge) && busy === 1'b1) begin
                if (exp_sda_q.size() == 0) check("sda_pending", 32'(exp_sda_q.size()), 32'd1);
                else check("sda_bit", 32'(sda), 32'(exp_sda_q.pop_front()));
            end
            if (done !== 1'b0) begin
                if (exp_done_q.size() == 0) check("done_pending", 32'(exp_done_q.size()), 32'd1);
                else check("done_cycle", 32'(cyc), 32'(exp_done_q.pop_front()));
            end
            if (crc_dv !== 1'b0) begin
                if (exp_crc_q.size() == 0) check("crc_pending", 32'(exp_crc_q.size()), 32'd1);
                else check("crc_data", 32'(crc_data), 32'(exp_crc_q.pop_front()));
            end
        end
    end

    task automatic issue(input logic [3:0] m, input bit edge_in_load, input int crc_wait);
        model_pattern(m, cur_val, cur_len);
        cur_mode = m;
        cur_idx = 0;
        mode = m;
        en = 1'b1;
        crc_valid = (crc_wait == 0);
        if (edge_in_load) pos_edge = 1'b1;
        if (cur_len == 0) begin
            @(posedge clk); #1;
            pos_edge = 1'b0;
            repeat (2) begin @(posedge clk); #1; end
            check("invalid_busy", 32'(busy), 32'd0);
            check("invalid_sda", 32'(sda), 32'(m_sda));
            en = 1'b0;
            return;
        end
        if (m == 4'd3) begin
            exp_crc_q.push_back(data);
            m_bytes[m_byte_num] = data;
            m_crc_en = 1'b1;
        end
        if (m == 4'd0) begin
            m_byte_num = 0;
            m_crc_en = 1'b0;
        end
        @(posedge clk); #1;
        pos_edge = 1'b0;
        mode = 4'($urandom_range(15, 0));
        if (crc_wait > 0) begin
            repeat (crc_wait) begin @(posedge clk); #1; end
            check("wait_busy", 32'(busy), 32'd1);
            check("wait_sda_hold", 32'(sda), 32'(m_sda));
            crc_valid = 1'b1;
            @(posedge clk); #1;
        end
    endtask

    task automatic edges(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            exp_sda_q.push_back(bit_at(cur_val, cur_len - 1 - cur_idx));
            repeat (gap - 1) begin @(posedge clk); #1; end
            if (next_pos) pos_edge = 1'b1;
            else neg_edge = 1'b1;
            next_pos = !next_pos;
            cur_idx++;
            if (cur_idx == cur_len) exp_done_q.push_back(cyc + 1);
            @(posedge clk); #1;
            pos_edge = 1'b0;
            neg_edge = 1'b0;
        end
    endtask

    task automatic finish_mode();
        en = 1'b0;
        if (cur_idx == cur_len) begin
            if (cur_mode == 4'd3) m_byte_num = 1 - m_byte_num;
            if (cur_mode == 4'd6) m_byte_num = 0;
            if (cur_mode == 4'd7) m_crc_en = 1'b0;
            m_sda = cur_val[0];
        end else begin
            m_crc_en = 1'b0;
            m_sda = bit_at(cur_val, cur_len - 1 - cur_idx);
        end
        repeat (2) begin @(posedge clk); #1; end
        check("idle_busy", 32'(busy), 32'd0);
        check("hold_sda", 32'(sda), 32'(m_sda));
        check("crc_en", 32'(crc_en), 32'(m_crc_en));
        check("sda_left", 32'(exp_sda_q.size()), 32'd0);
        check("done_left", 32'(exp_done_q.size()), 32'd0);
        check("crc_left", 32'(exp_crc_q.size()), 32'd0);
        exp_sda_q.delete();
        exp_done_q.delete();
        exp_crc_q.delete();
    endtask

    task automatic run(input logic [3:0] m, input bit eil, input int crc_wait, input int n, input int gap);
        issue(m, eil, crc_wait);
        if (cur_len > 0) begin
            edges(n, gap);
            finish_mode();
        end
    endtask

    initial begin
        logic [3:0] m;
        int         pick;
        int         k;
        int         cw;
        m_bytes[0] = 8'h00;
        m_bytes[1] = 8'h00;
        m_byte_num = 0;
        m_crc_en = 1'b0;
        m_sda = 1'b1;
        next_pos = 1'b1;

        #1 rst = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("rst_sda", 32'(sda), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_crc_en", 32'(crc_en), 32'd0);
        check("rst_crc_dv", 32'(crc_dv), 32'd0);
        check("rst_crc_data", 32'(crc_data), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Single byte, edges every 4 clocks
        data = 8'hA5;
        run(4'd3, 1'b0, 0, 8, 4);
        run(4'd6, 1'b0, 0, 2, 2);

        // Two bytes then parity over 16'h3CF0
        data = 8'h3C;
        run(4'd3, 1'b0, 0, 8, 2);
        data = 8'hF0;
        run(4'd3, 1'b0, 0, 8, 1);
        run(4'd6, 1'b0, 0, 2, 3);

        // Token, then CRC value with a late valid
        run(4'd5, 1'b0, 0, 4, 2);
        check("crc_en_before_value", 32'(crc_en), 32'd1);
        crc_value = 5'h13;
        run(4'd7, 1'b0, 10, 5, 2);

        // Abort after 3 edges, then a full byte from the MSB
        data = 8'h5A;
        run(4'd3, 1'b0, 0, 3, 2);
        data = 8'hC3;
        run(4'd3, 1'b0, 0, 8, 2);

        // Preamble with a strobe in the load cycle
        pre = 2'b10;
        run(4'd0, 1'b1, 0, 2, 3);

        // Reset in the middle of a CRC value
        data = 8'h96;
        run(4'd3, 1'b0, 0, 8, 1);
        crc_value = 5'h0A;
        issue(4'd7, 1'b0, 0);
        edges(2, 2);
        #3 rst = 1'b0;
        #1;
        check("midrst_sda", 32'(sda), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_crc_en", 32'(crc_en), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        exp_sda_q.delete();
        exp_done_q.delete();
        exp_crc_q.delete();
        m_bytes[0] = 8'h00;
        m_bytes[1] = 8'h00;
        m_byte_num = 0;
        m_crc_en = 1'b0;
        m_sda = 1'b1;
        en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        run(4'd6, 1'b0, 0, 2, 2);
        data = 8'h81;
        run(4'd3, 1'b0, 0, 8, 1);
        run(4'd6, 1'b0, 0, 2, 1);

        // Randomised transactions, including aborts and unsupported modes
        for (int t = 0; t < 40; t++) begin
            pick = $urandom_range(9, 0);
            case (pick)
                0:       m = 4'd0;
                1, 2, 3: m = 4'd3;
                4:       m = 4'd5;
                5:       m = 4'd6;
                6:       m = 4'd7;
                7:       m = 4'd8;
                8:       m = 4'd9;
                default: m = 4'($urandom_range(15, 10));
            endcase
            data = 8'($urandom);
            pre = 2'($urandom);
            crc_value = 5'($urandom);
            cw = ((m == 4'd7) && ($urandom_range(1, 0) == 1)) ? $urandom_range(5, 1) : 0;
            issue(m, bit'($urandom_range(1, 0)), cw);
            if (cur_len > 0) begin
                k = cur_len;
                if ((cur_len > 1) && ($urandom_range(7, 0) == 0)) k = $urandom_range(cur_len - 1, 0);
                edges(k, $urandom_range(4, 1));
                finish_mode();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
